// File: rtl/writeback_queue_if.sv
// writeback_queue_if: request, register-file write and bypass signals of the writeback queue.
//   master: drives load_*/alu_* requests and rs*_sel; observes everything else
//   slave : the queue itself; drives ready, write*, count, overflow, rs*_hit, rs*_fwd
interface writeback_queue_if #(
    parameter int DEPTH = 4
);
    logic                     load_valid;
    logic [4:0]               load_rd;
    logic [31:0]              load_data;
    logic                     alu_valid;
    logic [4:0]               alu_rd;
    logic [31:0]              alu_data;
    logic                     ready;
    logic                     write;
    logic [4:0]               write_reg;
    logic [31:0]              write_data;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic [4:0]               rs1_sel;
    logic [4:0]               rs2_sel;
    logic                     rs1_hit;
    logic                     rs2_hit;
    logic [31:0]              rs1_fwd;
    logic [31:0]              rs2_fwd;

    modport master (
        output load_valid, load_rd, load_data, alu_valid, alu_rd, alu_data, rs1_sel, rs2_sel,
        input  ready, write, write_reg, write_data, count, overflow, rs1_hit, rs2_hit, rs1_fwd, rs2_fwd
    );

    modport slave (
        input  load_valid, load_rd, load_data, alu_valid, alu_rd, alu_data, rs1_sel, rs2_sel,
        output ready, write, write_reg, write_data, count, overflow, rs1_hit, rs2_hit, rs1_fwd, rs2_fwd
    );
endinterface

// File: rtl/writeback_queue.sv
// writeback_queue: merges load-return and ALU results into one register-file write port.
//   clock, reset : single clock, synchronous active-high reset
//   bus (slave)  : load/alu requests in, registered write/write_reg/write_data out,
//                  ready/count/overflow status, rs1/rs2 bypass lookup
//   CORE         : core index, debug identification only
//   DEPTH        : queue entries, power of two from 2 to 16
//   Define WRITEBACK_QUEUE_BYPASS_EN to enable the bypass lookup; otherwise hits/fwds read 0.
module writeback_queue #(
    parameter int CORE  = 0,
    parameter int DEPTH = 4
) (
    input logic             clock,
    input logic             reset,
    writeback_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    rd_q   [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d, alu_slot;
    logic [CW-1:0] count_q, count_d, free;
    logic          pop, load_req, alu_req, load_acc, alu_acc, drop;
    logic          write_q, write_d, ovf_q, ovf_d;
    logic [4:0]    wreg_q, wreg_d;
    logic [31:0]   wdata_q, wdata_d;

    always_comb begin
        pop      = count_q != '0;
        // a slot freed by this edge's pop can be refilled on the same edge
        free     = CW'(DEPTH) - count_q + CW'(pop);
        load_req = bus.load_valid && bus.load_rd != 5'd0;
        alu_req  = bus.alu_valid && bus.alu_rd != 5'd0;
        // load is older, so it claims space first and the ALU push is dropped first
        load_acc = load_req && free != '0;
        alu_acc  = alu_req && free > CW'(load_acc);
        drop     = (load_req && !load_acc) || (alu_req && !alu_acc);
        alu_slot = wptr_q + AW'(load_acc);
        rptr_d   = rptr_q + AW'(pop);
        wptr_d   = wptr_q + AW'(load_acc) + AW'(alu_acc);
        count_d  = count_q + CW'(load_acc) + CW'(alu_acc) - CW'(pop);
        write_d  = pop;
        wreg_d   = pop ? rd_q[rptr_q] : wreg_q;
        wdata_d  = pop ? data_q[rptr_q] : wdata_q;
        ovf_d    = ovf_q | drop;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            write_q <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            write_q <= write_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            ovf_q   <= ovf_d;
        end
    end

    // entry storage needs no reset: validity is tracked by the pointers and count
    always_ff @(posedge clock) begin
        if (!reset && load_acc) begin
            rd_q[wptr_q]   <= bus.load_rd;
            data_q[wptr_q] <= bus.load_data;
        end
        if (!reset && alu_acc) begin
            rd_q[alu_slot]   <= bus.alu_rd;
            data_q[alu_slot] <= bus.alu_data;
        end
    end

    assign bus.ready      = count_q <= CW'(DEPTH - 2);
    assign bus.write      = write_q;
    assign bus.write_reg  = wreg_q;
    assign bus.write_data = wdata_q;
    assign bus.count      = count_q;
    assign bus.overflow   = ovf_q;

`ifdef WRITEBACK_QUEUE_BYPASS_EN
    // scan oldest to newest so the youngest matching producer wins
    function automatic logic [32:0] lookup(input logic [4:0] sel);
        logic [32:0]   r;
        logic [AW-1:0] idx;
        r = (write_q && wreg_q == sel) ? {1'b1, wdata_q} : 33'd0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rptr_q + AW'(i);
            if (CW'(i) < count_q && rd_q[idx] == sel) r = {1'b1, data_q[idx]};
        end
        return sel == 5'd0 ? 33'd0 : r;
    endfunction

    always_comb begin
        {bus.rs1_hit, bus.rs1_fwd} = lookup(bus.rs1_sel);
        {bus.rs2_hit, bus.rs2_fwd} = lookup(bus.rs2_sel);
    end
`else
    assign bus.rs1_hit = 1'b0;
    assign bus.rs2_hit = 1'b0;
    assign bus.rs1_fwd = '0;
    assign bus.rs2_fwd = '0;
`endif
endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: random and directed stimulus against a queue-based reference model.
module tb_writeback_queue;
    localparam int DEPTH = 4;
`ifdef WRITEBACK_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    writeback_queue_if #(.DEPTH(DEPTH)) wb ();
    writeback_queue #(.CORE(0), .DEPTH(DEPTH)) dut (.clock(clock), .reset(reset), .bus(wb));

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic        m_write;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    logic        m_ovf;
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] m_lookup(input logic [4:0] sel);
        if (!BYP || sel == 5'd0) return 33'd0;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].rd == sel) return {1'b1, mq[i].data};
        if (m_write && m_reg == sel) return {1'b1, m_data};
        return 33'd0;
    endfunction

    task automatic m_reset();
        mq.delete();
        m_write = 1'b0;
        m_reg   = '0;
        m_data  = '0;
        m_ovf   = 1'b0;
    endtask

    task automatic step(input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                        input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic [4:0] s1, input logic [4:0] s2, input logic rst);
        int   free;
        ent_t e;
        logic [32:0] b1, b2;
        wb.load_valid = lv; wb.load_rd = lrd; wb.load_data = ld;
        wb.alu_valid  = av; wb.alu_rd  = ard; wb.alu_data  = ad;
        wb.rs1_sel    = s1; wb.rs2_sel = s2;
        reset         = rst;
        @(negedge clock);
        b1 = m_lookup(s1);
        b2 = m_lookup(s2);
        check("count", 32'(wb.count), 32'(mq.size()));
        check("ready", 32'(wb.ready), 32'(mq.size() <= DEPTH - 2));
        check("write", 32'(wb.write), 32'(m_write));
        check("write_reg", 32'(wb.write_reg), 32'(m_reg));
        check("write_data", wb.write_data, m_data);
        check("overflow", 32'(wb.overflow), 32'(m_ovf));
        check("rs1_hit", 32'(wb.rs1_hit), 32'(b1[32]));
        check("rs1_fwd", wb.rs1_fwd, b1[31:0]);
        check("rs2_hit", 32'(wb.rs2_hit), 32'(b2[32]));
        check("rs2_fwd", wb.rs2_fwd, b2[31:0]);
        @(posedge clock);
        if (rst) m_reset();
        else begin
            free = DEPTH - mq.size();
            if (mq.size() > 0) begin
                e = mq.pop_front();
                m_write = 1'b1; m_reg = e.rd; m_data = e.data;
                free++;
            end else m_write = 1'b0;
            if (lv && lrd != 0) begin
                if (free > 0) begin mq.push_back('{lrd, ld}); free--; end else m_ovf = 1'b1;
            end
            if (av && ard != 0) begin
                if (free > 0) begin mq.push_back('{ard, ad}); free--; end else m_ovf = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic dual(input logic [4:0] a, input logic [4:0] b);
        step(1, a, 32'(a) * 32'h11, 1, b, 32'(b) * 32'h11, 0, 0, 0);
    endtask

    initial begin
        m_reset();
        wb.load_valid = 0; wb.load_rd = 0; wb.load_data = 0;
        wb.alu_valid  = 0; wb.alu_rd  = 0; wb.alu_data  = 0;
        wb.rs1_sel    = 0; wb.rs2_sel = 0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_count", 32'(wb.count), 0);
        check("rst_write", 32'(wb.write), 0);
        check("rst_ready", 32'(wb.ready), 1);
        check("rst_ovf", 32'(wb.overflow), 0);

        step(0, 0, 0, 1, 5, 32'h1234, 0, 0, 0);
        check("lat_w0", 32'(wb.write), 0);
        idle();
        check("lat_w1", 32'(wb.write), 1);
        check("lat_reg", 32'(wb.write_reg), 5);
        check("lat_data", wb.write_data, 32'h1234);
        idle();
        check("lat_w2", 32'(wb.write), 0);

        step(1, 3, 32'hA, 1, 4, 32'hB, 0, 0, 0);
        idle();
        check("ord_reg0", 32'(wb.write_reg), 3);
        check("ord_data0", wb.write_data, 32'hA);
        idle();
        check("ord_w1", 32'(wb.write), 1);
        check("ord_reg1", 32'(wb.write_reg), 4);
        check("ord_data1", wb.write_data, 32'hB);
        idle();

        step(0, 0, 0, 1, 0, 32'hFFFF, 0, 0, 0);
        check("rd0_count", 32'(wb.count), 0);
        idle();
        check("rd0_write", 32'(wb.write), 0);

        dual(1, 2);
        dual(3, 4);
        dual(5, 6);
        check("full_count", 32'(wb.count), 4);
        check("full_ready", 32'(wb.ready), 0);
        check("full_ovf0", 32'(wb.overflow), 0);
        dual(7, 8);
        check("drop_count", 32'(wb.count), 4);
        check("drop_ovf", 32'(wb.overflow), 1);
        repeat (6) idle();
        check("ovf_sticky", 32'(wb.overflow), 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("ovf_clr", 32'(wb.overflow), 0);

        step(1, 7, 32'h1, 1, 7, 32'h2, 0, 0, 0);
        wb.rs1_sel = 7;
        wb.rs2_sel = 0;
        #1;
        check("byp_hit", 32'(wb.rs1_hit), 32'(BYP));
        check("byp_fwd", wb.rs1_fwd, BYP ? 32'h2 : 32'h0);
        check("byp_zero", 32'(wb.rs2_hit), 0);
        repeat (3) idle();

        dual(9, 10);
        dual(11, 12);
        check("pre_rst_count", 32'(wb.count), 3);
        step(1, 13, 32'h5, 0, 0, 0, 0, 0, 1);
        check("mid_rst_count", 32'(wb.count), 0);
        check("mid_rst_write", 32'(wb.write), 0);
        check("mid_rst_ovf", 32'(wb.overflow), 0);
        for (int i = 0; i < 4; i++) begin
            idle();
            check("mid_rst_nowr", 32'(wb.write), 0);
        end

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 $urandom_range(0, 49) == 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
